// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the multiplexed seven-segment driver.
//   SEG_GLYPH  : active-high gfedcba glyphs for hex nibbles 0..F
//   SEG_OFF    : all segments dark (active-high)
//   disp_rec_t : staging/shadow record (data, dp, blank, lz_en), sized for the
//                largest supported display; unused upper digits stay zero.
package seg7_pkg;

    localparam int MAX_DIGITS = 16;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [4*MAX_DIGITS-1:0] data;
        logic [MAX_DIGITS-1:0]   dp;
        logic [MAX_DIGITS-1:0]   blank;
        logic                    lz_en;
    } disp_rec_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-high gfedcba glyph.
//   nibble_i : 4-bit hex value
//   seg_o    : segments, seg_o[0]=a ... seg_o[6]=g
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_GLYPH[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment scan driver with double buffering.
//   clk, reset     : system clock, asynchronous active-low reset
//   data_i         : DIGITS hex nibbles, digit 0 in the low nibble
//   dp_i, blank_i  : per-digit decimal point / blanking requests
//   lz_en_i        : leading-zero suppression enable
//   load_i         : strobe capturing the inputs into staging
//   led, dp        : registered segment outputs (polarity per SEG_ACTIVE_LOW)
//   cs             : registered one-hot digit select (polarity per CS_ACTIVE_LOW)
//   frame_o        : one-cycle pulse when the scan wraps to digit 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int DIV            = 100000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int CS_ACTIVE_LOW  = 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic                  lz_en_i,
    input  logic                  load_i,
    output logic [6:0]            led,
    output logic                  dp,
    output logic [DIGITS-1:0]     cs,
    output logic                  frame_o
);

    localparam int PW = $clog2(DIV);

    // XOR masks that turn active-high internal values into pin polarity.
    localparam logic [6:0]        LED_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] CS_OFF  = (CS_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        LED_OFF = SEG_OFF ^ LED_INV;

    logic [PW-1:0]     presc_q, presc_d;
    logic [3:0]        idx_q, idx_d;
    disp_rec_t         staging_q, staging_d;
    disp_rec_t         shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic              guard_q, guard_d;
    logic              frame_q, frame_d;
    logic [6:0]        led_q, led_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] cs_q, cs_d;

    logic              tick;
    logic [3:0]        nibble;
    logic [6:0]        glyph;
    logic              upper_nz;
    logic              suppress;
    logic [DIGITS-1:0] sel;

    assign tick = (presc_q == PW'(DIV - 1));

    // Scan position, frame pulse and double-buffer transfer.
    always_comb begin
        presc_d   = tick ? '0 : presc_q + PW'(1);
        idx_d     = idx_q;
        staging_d = staging_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        frame_d   = 1'b0;
        guard_d   = tick;
        if (tick) begin
            idx_d = (idx_q == 4'(DIGITS - 1)) ? 4'd0 : idx_q + 4'd1;
            if (idx_d == 4'd0) begin
                frame_d = 1'b1;
                // Transfer uses the pre-edge staging; a same-cycle load waits a frame.
                if (pending_q) begin
                    shadow_d  = staging_q;
                    pending_d = 1'b0;
                end
            end
        end
        if (load_i) begin
            staging_d.data  = (4*MAX_DIGITS)'(data_i);
            staging_d.dp    = MAX_DIGITS'(dp_i);
            staging_d.blank = MAX_DIGITS'(blank_i);
            staging_d.lz_en = lz_en_i;
            pending_d       = 1'b1;
        end
    end

    // Single decoder on the nibble of the digit about to be shown.
    assign nibble = shadow_d.data[{idx_d, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    assign sel = DIGITS'(1) << idx_q;

    // Output registers; guard cycle keeps cs dark while led/dp change.
    always_comb begin
        upper_nz = 1'b0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k >= int'(idx_d) && shadow_d.data[4*k +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        suppress = shadow_d.lz_en && (idx_d != 4'd0) && !upper_nz;

        led_d = led_q;
        dp_d  = dp_q;
        cs_d  = cs_q;
        if (tick) begin
            cs_d = CS_OFF;
            if (shadow_d.blank[idx_d]) begin
                led_d = LED_OFF;
                dp_d  = DP_INV;
            end else begin
                led_d = (suppress ? SEG_OFF : glyph) ^ LED_INV;
                dp_d  = shadow_d.dp[idx_d] ^ DP_INV;
            end
        end else if (guard_q) begin
            cs_d = shadow_q.blank[idx_q] ? CS_OFF : (sel ^ CS_OFF);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            idx_q     <= 4'(DIGITS - 1);
            staging_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            guard_q   <= 1'b0;
            frame_q   <= 1'b0;
            led_q     <= LED_OFF;
            dp_q      <= DP_INV;
            cs_q      <= CS_OFF;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            guard_q   <= guard_d;
            frame_q   <= frame_d;
            led_q     <= led_d;
            dp_q      <= dp_d;
            cs_q      <= cs_d;
        end
    end

    assign led     = led_q;
    assign dp      = dp_q;
    assign cs      = cs_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4).
// A behavioural model derives expected outputs from the count of clock edges
// since reset release plus the staging/shadow contents; literal checks pin it.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int SEG_AL = 0;
    localparam int CS_AL  = 1;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic        lz_en_i = 1'b0;
    logic        load_i = 1'b0;
    logic [6:0]  led;
    logic        dp;
    logic [3:0]  cs;
    logic        frame_o;

    seg7_scan_driver #(
        .DIGITS         (DIGITS),
        .DIV            (DIV),
        .SEG_ACTIVE_LOW (SEG_AL),
        .CS_ACTIVE_LOW  (CS_AL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_i  (data_i),
        .dp_i    (dp_i),
        .blank_i (blank_i),
        .lz_en_i (lz_en_i),
        .load_i  (load_i),
        .led     (led),
        .dp      (dp),
        .cs      (cs),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_e;          // clock edges since reset release
    logic [15:0] st_data, sh_data;
    logic [3:0]  st_dp, st_bl, sh_dp, sh_bl;
    logic        st_lz, sh_lz, m_pend;
    int          last_frame_e = -1;

    function automatic int cur_idx(input int e);
        return (DIGITS - 1 + e / DIV) % DIGITS;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_e = 0;
            st_data = '0; st_dp = '0; st_bl = '0; st_lz = 1'b0;
            sh_data = '0; sh_dp = '0; sh_bl = '0; sh_lz = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_e++;
            if (m_e % DIV == 0 && cur_idx(m_e) == 0 && m_pend) begin
                sh_data = st_data; sh_dp = st_dp; sh_bl = st_bl; sh_lz = st_lz;
                m_pend = 1'b0;
            end
            if (load_i) begin
                st_data = data_i; st_dp = dp_i; st_bl = blank_i; st_lz = lz_en_i;
                m_pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] eled;
        logic       edp;
        logic [3:0] ecs;
        logic       efr;
        logic [3:0] nib;
        bit         supp;
        int         i;
        if (armed) begin
            eled = 7'h00; edp = 1'b0; ecs = 4'b0000; efr = 1'b0;
            if (reset && m_e >= DIV) begin
                i    = cur_idx(m_e);
                nib  = 4'(sh_data >> (4 * i));
                supp = sh_lz && (i > 0) && ((sh_data >> (4 * i)) == 16'h0);
                if (sh_bl[i]) begin
                    eled = 7'h00; edp = 1'b0;
                end else begin
                    eled = supp ? 7'h00 : GLYPH[nib];
                    edp  = sh_dp[i];
                end
                if (m_e % DIV != 0 && !sh_bl[i]) ecs = 4'(1 << i);
                efr = (m_e % DIV == 0) && (i == 0);
            end
            if (SEG_AL != 0) begin eled = ~eled; edp = ~edp; end
            if (CS_AL != 0) ecs = ~ecs;
            chk("model_led", 32'(led), 32'(eled));
            chk("model_dp", 32'(dp), 32'(edp));
            chk("model_cs", 32'(cs), 32'(ecs));
            chk("model_frame", 32'(frame_o), 32'(efr));
            if (!reset) begin
                last_frame_e = -1;
            end else if (frame_o === 1'b1) begin
                if (last_frame_e >= 0) chk("frame_period", 32'(m_e - last_frame_e), 32'(DIGITS * DIV));
                last_frame_e = m_e;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int t);
        int guard = 0;
        while (m_e < t && guard < 10000) begin
            cyc();
            guard++;
        end
        if (m_e < t) chk("run_to_timeout", 32'(m_e), 32'(t));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic lz);
        data_i = d; dp_i = p; blank_i = b; lz_en_i = lz; load_i = 1'b1;
        cyc();
        load_i = 1'b0;
    endtask

    initial begin
        int hits;
        #2 reset = 1'b0;
        armed = 1'b1;
        cyc(); cyc();
        reset = 1'b1;

        // Reset state and first frame.
        chk("rst_cs", 32'(cs), 32'h0F);
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_dp", 32'(dp), 32'h0);
        run_to(3);
        chk("pre_tick_frame", 32'(frame_o), 32'h0);
        run_to(4);
        chk("tick1_frame", 32'(frame_o), 32'h1);
        chk("tick1_led", 32'(led), 32'h3F);
        chk("tick1_cs_guard", 32'(cs), 32'h0F);
        run_to(5);
        chk("tick1_cs", 32'(cs), 32'h0E);

        // Mid-frame load: old value holds until the wrap.
        do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        run_to(9);
        chk("hold_d1_led", 32'(led), 32'h3F);
        chk("hold_d1_cs", 32'(cs), 32'h0D);
        run_to(17);
        chk("hold_d3_led", 32'(led), 32'h3F);
        run_to(21);
        chk("new_d0_led", 32'(led), 32'h66);
        chk("new_d0_cs", 32'(cs), 32'h0E);
        run_to(33);
        chk("new_d3_led", 32'(led), 32'h06);
        chk("new_d3_cs", 32'(cs), 32'h07);

        // Leading-zero suppression with a dp on a suppressed digit.
        run_to(34);
        do_load(16'h0050, 4'b1000, 4'b0000, 1'b1);
        run_to(37);
        chk("lz_d0_led", 32'(led), 32'h3F);
        run_to(41);
        chk("lz_d1_led", 32'(led), 32'h6D);
        run_to(45);
        chk("lz_d2_led", 32'(led), 32'h00);
        chk("lz_d2_cs", 32'(cs), 32'h0B);
        run_to(49);
        chk("lz_d3_led", 32'(led), 32'h00);
        chk("lz_d3_dp", 32'(dp), 32'h1);
        chk("lz_d3_cs", 32'(cs), 32'h07);

        // Blanked digit 2 over three frames.
        run_to(50);
        do_load(16'h8888, 4'b0000, 4'b0100, 1'b0);
        run_to(52);
        hits = 0;
        repeat (3 * DIGITS * DIV) begin
            cyc();
            if (cs == 4'b1011) hits++;
        end
        chk("blank_hits", 32'(hits), 32'h0);

        // Load coinciding with a wrap tick.
        run_to(117);
        do_load(16'h5678, 4'b0000, 4'b0000, 1'b0);
        run_to(131);
        do_load(16'h9ABC, 4'b0000, 4'b0000, 1'b0);
        run_to(133);
        chk("wrapld_old_led", 32'(led), 32'h7F);
        run_to(149);
        chk("wrapld_new_led", 32'(led), 32'h39);

        // Reset during digit 2 with a load pending.
        run_to(150);
        do_load(16'hFFFF, 4'b1111, 4'b0000, 1'b0);
        run_to(157);
        reset = 1'b0;
        #1;
        chk("midrst_cs", 32'(cs), 32'h0F);
        chk("midrst_led", 32'(led), 32'h00);
        chk("midrst_dp", 32'(dp), 32'h0);
        chk("midrst_frame", 32'(frame_o), 32'h0);
        cyc(); cyc();
        reset = 1'b1;
        run_to(4);
        chk("postrst_led", 32'(led), 32'h3F);
        chk("postrst_frame", 32'(frame_o), 32'h1);
        run_to(5);
        chk("postrst_cs", 32'(cs), 32'h0E);

        // Randomized loads checked by the model.
        repeat (600) begin
            if ($urandom_range(7) == 0) begin
                data_i  = 16'($urandom);
                dp_i    = 4'($urandom);
                blank_i = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
                lz_en_i = 1'($urandom);
                load_i  = 1'b1;
            end else begin
                load_i = 1'b0;
            end
            cyc();
        end
        load_i = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
